// File: rtl/pulse_train_generator.sv
// -----------------------------------------------------------------------------
// pulse_train_generator
//
// Emits a programmable train of pulses on a single-bit line. Each pulse is
// high for H cycles and low for L cycles; N pulses are produced per train.
// Registered rising/falling strobes accompany the line so local logic gets
// edge events without re-detecting them.
//
// Ports:
//   clk          system clock, all logic on rising edge
//   rst          synchronous reset, active-high
//   start        request a new train (only honoured in IDLE)
//   abort        terminate a train in progress
//   high_cycles  high phase length in cycles (0 treated as 1), latched on start
//   low_cycles   low phase length in cycles (0 treated as 1), latched on start
//   num_pulses   pulse count, latched on start (0 yields an empty train)
//   pulse_out    generated pulse line (registered)
//   rising_out   1-cycle strobe in the first cycle pulse_out is 1
//   falling_out  1-cycle strobe in the first cycle pulse_out is 0 after 1
//   busy         train in progress
//   done         1-cycle strobe, train completed normally
// -----------------------------------------------------------------------------
module pulse_train_generator #(
  parameter int DUR_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DUR_W-1:0] high_cycles,
  input  logic [DUR_W-1:0] low_cycles,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             pulse_out,
  output logic             rising_out,
  output logic             falling_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t           state;
  state_t           next_state;

  // Latched phase lengths are stored as (duration - 1) so they load straight
  // into the down-counter.
  logic [DUR_W-1:0] high_m1;
  logic [DUR_W-1:0] low_m1;
  logic [DUR_W-1:0] phase_cnt;
  logic [NUM_W-1:0] pulse_cnt;

  logic             phase_end;
  logic             last_pulse;

  // A zero duration is treated as one cycle, so the reload value saturates at 0.
  function automatic logic [DUR_W-1:0] dur_m1(input logic [DUR_W-1:0] d);
    return (d == '0) ? '0 : d - DUR_W'(1);
  endfunction

  assign phase_end  = (phase_cnt == '0);
  // pulse_cnt holds the pulses still to finish, including the current one.
  assign last_pulse = (pulse_cnt <= NUM_W'(1));

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path through the case statement can leave it unassigned and
  // infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          next_state = (num_pulses != '0) ? S_HIGH : S_DONE;
        end
      end
      S_HIGH: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (phase_end) begin
          next_state = S_LOW;
        end
      end
      S_LOW: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (phase_end) begin
          next_state = last_pulse ? S_DONE : S_HIGH;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      high_m1     <= '0;
      low_m1      <= '0;
      phase_cnt   <= '0;
      pulse_cnt   <= '0;
      pulse_out   <= 1'b0;
      rising_out  <= 1'b0;
      falling_out <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= next_state;

      // Outputs are decoded from the upcoming state so they appear registered
      // in the same cycle the state takes effect. Strobes fire only on actual
      // line transitions, which covers abort out of the high phase as well.
      pulse_out   <= (next_state == S_HIGH);
      rising_out  <= (next_state == S_HIGH) && (state != S_HIGH);
      falling_out <= (next_state != S_HIGH) && (state == S_HIGH);
      busy        <= (next_state == S_HIGH) || (next_state == S_LOW);
      done        <= (next_state == S_DONE);

      case (state)
        S_IDLE: begin
          if (next_state == S_HIGH) begin
            high_m1   <= dur_m1(high_cycles);
            low_m1    <= dur_m1(low_cycles);
            pulse_cnt <= num_pulses;
            phase_cnt <= dur_m1(high_cycles);
          end
        end
        S_HIGH: begin
          if (next_state == S_LOW) begin
            phase_cnt <= low_m1;
          end else if (next_state == S_HIGH) begin
            phase_cnt <= phase_cnt - DUR_W'(1);
          end
        end
        S_LOW: begin
          if (next_state == S_HIGH) begin
            phase_cnt <= high_m1;
            pulse_cnt <= pulse_cnt - NUM_W'(1);
          end else if (next_state == S_LOW) begin
            phase_cnt <= phase_cnt - DUR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
